// File: rtl/iq_quarta_upmix_if.sv
// iq_quarta_upmix_if: sample/handshake bundle for the fs/4 up-mixer
//   i, q, in_valid, phase_sync : upstream sample and control (into block)
//   in_ready                   : block can take the sample
//   io, qo, phase_o, out_valid : rotated sample towards DAC path
//   out_ready                  : downstream accepts io/qo
//   sat_flag, sat_clr          : sticky saturation status and its clear
interface iq_quarta_upmix_if #(
   parameter int W = 16
);
   logic signed [W-1:0] i;
   logic signed [W-1:0] q;
   logic in_valid;
   logic in_ready;
   logic phase_sync;
   logic signed [W-1:0] io;
   logic signed [W-1:0] qo;
   logic out_valid;
   logic out_ready;
   logic [1:0] phase_o;
   logic sat_flag;
   logic sat_clr;
   modport slave (
      input  i, q, in_valid, phase_sync, out_ready, sat_clr,
      output in_ready, io, qo, out_valid, phase_o, sat_flag
   );
   modport master (
      output i, q, in_valid, phase_sync, out_ready, sat_clr,
      input  in_ready, io, qo, out_valid, phase_o, sat_flag
   );
endinterface

// File: rtl/iq_quarta_upmix.sv
// iq_quarta_upmix: rotates each accepted I/Q sample by e^{+j*pi/2*n} through a two-stage valid/ready pipeline
//   clk, rst : clock and synchronous active-high reset
//   bus      : iq_quarta_upmix_if.slave (sample in, rotated sample out, saturation status)
//   IQ_UPMIX_SAT_EN defined: negating the most negative value clamps to max and sets sat_flag;
//   undefined: plain two's-complement wrap, sat_flag tied low
module iq_quarta_upmix #(
   parameter int W = 16,
   parameter int PHASE_INIT = 0
) (
   input logic clk,
   input logic rst,
   iq_quarta_upmix_if.slave bus
);
   logic s1_valid, s1_adv, s2_adv, acc, load;
   logic signed [W-1:0] s1_i, s1_q, ni, nq, io_n, qo_n;
   logic [1:0] ph, ph_use, s1_ph;
   assign s2_adv = !bus.out_valid || bus.out_ready;
   assign s1_adv = !s1_valid || s2_adv;
   assign bus.in_ready = s1_adv && !rst;
   assign acc = bus.in_valid && bus.in_ready;
   assign load = s2_adv && s1_valid;
   // a synced sample takes PHASE_INIT itself; the counter resumes one past it
   assign ph_use = bus.phase_sync ? 2'(PHASE_INIT) : ph;
`ifdef IQ_UPMIX_SAT_EN
   localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
   logic signed [W:0] ni_w, nq_w;
   logic i_ovf, q_ovf, sat_hit, sat_q;
   assign ni_w = -{s1_i[W-1], s1_i};
   assign nq_w = -{s1_q[W-1], s1_q};
   // only -2^(W-1) negates out of range, which shows as a sign-bit disagreement
   assign i_ovf = ni_w[W] ^ ni_w[W-1];
   assign q_ovf = nq_w[W] ^ nq_w[W-1];
   assign ni = i_ovf ? MAXV : ni_w[W-1:0];
   assign nq = q_ovf ? MAXV : nq_w[W-1:0];
   assign sat_hit = (s1_ph == 2'd1 && q_ovf) || (s1_ph == 2'd2 && (i_ovf || q_ovf)) || (s1_ph == 2'd3 && i_ovf);
   always_ff @(posedge clk) begin
      if (rst) sat_q <= 1'b0;
      else if (load && sat_hit) sat_q <= 1'b1;
      else if (bus.sat_clr) sat_q <= 1'b0;
   end
   assign bus.sat_flag = sat_q;
`else
   assign ni = -s1_i;
   assign nq = -s1_q;
   assign bus.sat_flag = 1'b0;
`endif
   assign io_n = s1_ph == 2'd0 ? s1_i : s1_ph == 2'd1 ? nq : s1_ph == 2'd2 ? ni : s1_q;
   assign qo_n = s1_ph == 2'd0 ? s1_q : s1_ph == 2'd1 ? s1_i : s1_ph == 2'd2 ? nq : ni;
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_i <= '0;
         s1_q <= '0;
         s1_ph <= '0;
         ph <= 2'(PHASE_INIT);
         bus.out_valid <= 1'b0;
         bus.io <= '0;
         bus.qo <= '0;
         bus.phase_o <= '0;
      end else begin
         if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (acc) begin
               s1_i <= bus.i;
               s1_q <= bus.q;
               s1_ph <= ph_use;
               ph <= ph_use + 2'd1;
            end
         end
         if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
               bus.io <= io_n;
               bus.qo <= qo_n;
               bus.phase_o <= s1_ph;
            end
         end
      end
   end
endmodule

// File: tb/tb_iq_quarta_upmix.sv
// tb_iq_quarta_upmix: random and directed stimulus against a complex-multiply reference of the fs/4 up-mixer
module tb_iq_quarta_upmix;
   localparam int W = 16;
   typedef struct {int io; int qo; int ph; int cyc;} smp_t;
   logic clk = 0, rst = 1;
   int checks = 0, failures = 0, cyc = 0, mph = 0;
   bit rnd_on = 0, held_v = 0;
   smp_t exp_q[$], got[$], held;
   iq_quarta_upmix_if #(.W(W)) bus ();
   iq_quarta_upmix #(.W(W), .PHASE_INIT(0)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic int red(input int x);
`ifdef IQ_UPMIX_SAT_EN
      return x > 32767 ? 32767 : x < -32768 ? -32768 : x;
`else
      return int'($signed(16'(x)));
`endif
   endfunction

   // (i + jq) * j^n, then reduced to the output width
   function automatic void rot(input int i, q, n, output int ro, qo);
      int re = i, im = q, t;
      for (int k = 0; k < n; k++) begin
         t = re;
         re = -im;
         im = t;
      end
      ro = red(re);
      qo = red(im);
   endfunction

   task automatic chk(input string name, input int act, req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         mph = 0;
         held_v = 0;
      end else begin
         if (bus.out_valid && held_v) begin
            chk("hold_io", bus.io, held.io);
            chk("hold_qo", bus.qo, held.qo);
            chk("hold_ph", bus.phase_o, held.ph);
         end
         held_v = bus.out_valid && !bus.out_ready;
         held = '{bus.io, bus.qo, bus.phase_o, cyc};
         if (bus.out_valid && bus.out_ready) begin
            smp_t e;
            if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("io", bus.io, e.io);
               chk("qo", bus.qo, e.qo);
               chk("phase_o", bus.phase_o, e.ph);
               got.push_back('{bus.io, bus.qo, bus.phase_o, cyc - e.cyc});
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            int n, ro, qo;
            n = bus.phase_sync ? 0 : mph;
            rot(bus.i, bus.q, n, ro, qo);
            exp_q.push_back('{ro, qo, n, cyc});
            mph = (n + 1) % 4;
         end
`ifndef IQ_UPMIX_SAT_EN
         chk("sat_flag_tied", bus.sat_flag, 0);
`endif
      end
   end

   always @(posedge clk) begin
      #1;
      if (rnd_on) bus.out_ready = $urandom_range(0, 3) != 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int si, sq, input bit sync);
      int t = 0;
      bit a;
      bus.i = 16'(si);
      bus.q = 16'(sq);
      bus.phase_sync = sync;
      bus.in_valid = 1;
      forever begin
         @(negedge clk);
         a = bus.in_ready;
         tick();
         if (a) break;
         if (++t > 200) begin
            chk("send_timeout", 0, 1);
            break;
         end
      end
      bus.in_valid = 0;
      bus.phase_sync = 0;
   endtask

   task automatic wait_got(input int n);
      int t = 0;
      while (got.size() < n && t < 300) begin
         tick();
         t++;
      end
      chk("drain_count", got.size(), n);
   endtask

   task automatic chk_got(input int k, input int io, qo, ph);
      if (k < got.size()) begin
         chk("lit_io", got[k].io, io);
         chk("lit_qo", got[k].qo, qo);
         chk("lit_ph", got[k].ph, ph);
      end else chk("lit_missing", got.size(), k + 1);
   endtask

   function automatic int rv();
      int s = $urandom_range(0, 7);
      return s == 0 ? -32768 : s == 1 ? 32767 : int'($signed(16'($urandom)));
   endfunction

   initial begin
      int b0;
      bus.i = 0;
      bus.q = 0;
      bus.in_valid = 0;
      bus.phase_sync = 0;
      bus.out_ready = 1;
      bus.sat_clr = 0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 0);
      chk("rst_out_valid", bus.out_valid, 0);
      chk("rst_io", bus.io, 0);
      chk("rst_qo", bus.qo, 0);
      chk("rst_phase_o", bus.phase_o, 0);
      chk("rst_sat_flag", bus.sat_flag, 0);
      tick();
      rst = 0;
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 1);
      tick();
      for (int k = 0; k < 4; k++) send(100, 200, 0);
      wait_got(4);
      chk_got(0, 100, 200, 0);
      chk_got(1, -200, 100, 1);
      chk_got(2, -100, -200, 2);
      chk_got(3, 200, -100, 3);
      chk("latency", got[0].cyc, 2);
      // backpressure: two samples fill the pipe, then in_ready must drop
      bus.out_ready = 0;
      send(10, 20, 0);
      send(30, 40, 0);
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", bus.in_ready, 0);
         chk("stall_out_valid", bus.out_valid, 1);
         chk("stall_phase_o", bus.phase_o, 0);
      end
      tick();
      bus.out_ready = 1;
      send(50, 60, 0);
      wait_got(7);
      chk_got(4, 10, 20, 0);
      chk_got(5, -40, 30, 1);
      chk_got(6, -50, -60, 2);
      send(3, 4, 0);
      send(5, 6, 0);
      send(1, 0, 1);
      send(2, 3, 0);
      wait_got(11);
      chk_got(7, 4, -3, 3);
      chk_got(8, 5, 6, 0);
      chk_got(9, 1, 0, 0);
      chk_got(10, -3, 2, 1);
      send(-32768, 5, 0);
      wait_got(12);
      repeat (3) tick();
`ifdef IQ_UPMIX_SAT_EN
      chk_got(11, 32767, -5, 2);
      chk("sat_set", bus.sat_flag, 1);
      bus.sat_clr = 1;
      tick();
      bus.sat_clr = 0;
      @(negedge clk);
      chk("sat_cleared", bus.sat_flag, 0);
`else
      chk_got(11, -32768, -5, 2);
      chk("sat_off", bus.sat_flag, 0);
`endif
      // reset with two samples in flight
      bus.out_ready = 0;
      send(11, 12, 0);
      send(13, 14, 0);
      rst = 1;
      tick();
      rst = 0;
      @(negedge clk);
      chk("rst_mid_out_valid", bus.out_valid, 0);
      tick();
      bus.out_ready = 1;
      b0 = got.size();
      send(7, 9, 0);
      wait_got(b0 + 1);
      chk_got(b0, 7, 9, 0);
      rnd_on = 1;
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 2)) tick();
         send(rv(), rv(), $urandom_range(0, 15) == 0);
      end
      rnd_on = 0;
      bus.out_ready = 1;
      wait_got(b0 + 1001);
      chk("model_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/iq_quarta_upmix.md
Name: iq_quarta_upmix

Overview:
- Complex up-converter by +fs/4: rotates each accepted I/Q sample by e^{+j*pi/2*n}, where n is a 2-bit phase advancing once per accepted sample.
- Transmit-side counterpart of the fs/4 quarter-rate down-mixer.
- Sits between baseband I/Q source and DAC/interpolator path.
- Two-stage valid/ready pipeline, with saturating negation and a sticky saturation flag.

Parameters:
- W, 16, sample width of i/q/io/qo (signed two's complement).
- PHASE_INIT, 0, phase value loaded at reset and on phase_sync (0..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- i  in  W  signed in-phase input.
- q  in  W  signed quadrature input.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept the input sample.
- phase_sync  in  1  when high with an accepted sample, that sample uses PHASE_INIT; phase continues from there.
- io  out  W  signed rotated in-phase output; also the real up-mixed output.
- qo  out  W  signed rotated quadrature output.
- out_valid  out  1  io/qo valid.
- out_ready  in  1  downstream accepts io/qo.
- phase_o  out  2  phase used for the sample currently on io/qo.
- sat_flag  out  1  sticky: a negation saturated since last clear.
- sat_clr  in  1  clears sat_flag.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset values: in_ready=0 during the rst cycle, then 1; out_valid=0; io=0; qo=0; phase_o=0; sat_flag=0; phase counter=PHASE_INIT; both stage valids=0.
- Handshake:
  - Transfer occurs when valid && ready on the same rising edge.
  - Upstream may hold i/q while in_ready=0; the block never drops or duplicates a sample.
  - io/qo/phase_o are stable while out_valid=1 && out_ready=0.
- Pipeline:
  - Stage 1 registers i, q, and the phase in use.
  - Stage 2 registers the rotated result onto io/qo/out_valid.
  - s2_adv = !out_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready through stage 2).
  - Latency 2 cycles from accept to out_valid with out_ready held 1.
  - Throughput 1 sample/cycle.
- Phase:
  - The phase counter increments mod 4 on each accepted input only; stalls do not advance it.
  - Wrap 3 -> 0.
  - If phase_sync=1 on an accepted sample, that sample uses PHASE_INIT and the counter becomes PHASE_INIT+1.
  - phase_sync without in_valid && in_ready is ignored.
- Rotation (n = stage-1 phase):
  - n=0: io=I, qo=Q.
  - n=1: io=-Q, qo=I.
  - n=2: io=-I, qo=-Q.
  - n=3: io=Q, qo=-I.
- Negation: computed at W+1 bits, then reduced to W (see Optional Feature). Operand -2^(W-1) is the only overflow case.
- sat_flag:
  - Set on the stage-2 load cycle when a saturation occurs.
  - sat_clr=1 clears it.
  - If set and clear coincide, set wins.
- Reset mid-operation: in-flight samples are discarded, out_valid drops the next cycle, and phase returns to PHASE_INIT.

Optional Feature:
- Macro: IQ_UPMIX_SAT_EN.
- Defined: negation of -2^(W-1) yields 2^(W-1)-1 (32767 for W=16) and sets sat_flag.
- Undefined:
  - Plain two's-complement wrap: -(-32768) = -32768.
  - sat_flag is tied to 0; sat_clr is ignored.
  - Saturation logic is removed.

Test Plan:
- Reset, then feed i=100, q=200 for 4 consecutive samples with out_ready=1.
  - Required (io,qo) sequence: (100,200), (-200,100), (-100,-200), (200,-100).
  - phase_o sequence: 0,1,2,3.
  - First out_valid exactly 2 cycles after the first accept.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream.
  - io/qo/phase_o frozen; in_ready falls after 2 samples fill the pipeline.
  - Phase does not advance during the stall.
  - No loss or duplication when out_ready returns.
- Sync: assert phase_sync on the 3rd sample (i=1, q=0), PHASE_INIT=0.
  - 3rd output = (1,0) with phase_o=0; 4th output phase_o=1.
- Saturation, i=-32768, q=5 at phase 2:
  - Macro defined: io=32767, qo=-5, sat_flag=1 until sat_clr pulses.
  - Macro undefined: io=-32768, qo=-5, sat_flag=0.
- Reset mid-stream with 2 samples in flight:
  - out_valid=0 the cycle after rst.
  - The next accepted sample (7,9) emerges as (7,9) with phase_o=0.
- Random valid/ready toggling over 1000 samples:
  - Output stream matches the reference rotation model sample-for-sample.
  - Phase is continuous mod 4.
